// File: rtl/serial_pattern_gen_pkg.sv
// Shared types and helpers for the serial pattern generator: FSM state,
// reset constants and the effective-length rule.
package serial_pattern_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } state_t;

  localparam logic RST_PAT_BIT = 1'b0;
  localparam int   RST_IDX     = 0;

  // A zero or oversize length request means "send the whole pattern".
  function automatic int eff_len(input int len, input int width);
    return (len == 0 || len > width) ? width : len;
  endfunction

endpackage

// File: rtl/pattern_shreg.sv
// Captured pattern register with a down-counting bit index and a bit-select
// port used by the top-level FSM to register the next serial bit.
module pattern_shreg
  import serial_pattern_gen_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap,
  input  logic [WIDTH-1:0] cap_pat,
  input  logic             set,
  input  logic             dec,
  input  logic [CNT_W-1:0] sel_idx,
  output logic [CNT_W-1:0] idx,
  output logic             sel_bit
);

  logic [WIDTH-1:0] pat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q <= {WIDTH{RST_PAT_BIT}};
      idx   <= CNT_W'(RST_IDX);
    end else begin
      if (cap) pat_q <= cap_pat;
      if (set)      idx <= sel_idx;
      else if (dec) idx <= idx - CNT_W'(1);
    end
  end

  // On capture the select looks through to the incoming pattern so the first
  // bit can be registered on the same edge that captures it.
  always_comb begin
    sel_bit = 1'b0;
    for (int i = 0; i < WIDTH; i++)
      if (CNT_W'(i) == sel_idx) sel_bit = cap ? cap_pat[i] : pat_q[i];
  end

endmodule

// File: rtl/serial_pattern_gen.sv
// Serial bit-pattern transmitter, MSB-first, all outputs registered.
// Optional repeat-with-gap mode enabled by SERIAL_PATTERN_GEN_LOOP_EN.
module serial_pattern_gen
  import serial_pattern_gen_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int CNT_W = 4,
  parameter int GAP   = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Pattern,
  input  logic [CNT_W-1:0] Len,
  input  logic             Abort,
`ifdef SERIAL_PATTERN_GEN_LOOP_EN
  input  logic             Loop,
`endif
  output logic             Out,
  output logic             Valid,
  output logic             Busy,
  output logic             Done
);

  state_t           state_q, state_d;
  logic             out_q, out_d, vld_q, vld_d, busy_q, busy_d, done_q, done_d;
  logic [CNT_W-1:0] len_q, len_d, len_eff, idx, sel_idx;
  logic             cap, set, dec, sel_bit;

`ifdef SERIAL_PATTERN_GEN_LOOP_EN
  localparam int             GW     = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0]  GAP_LD = GW'((GAP > 0) ? GAP - 1 : 0);
  logic [GW-1:0] gcnt_q, gcnt_d;
`else
  // GAP only shapes the loop mode; kept referenced in single-shot builds.
  if (GAP < 0) begin : g_gap_unused
  end
`endif

  assign len_eff = CNT_W'(eff_len(int'(Len), WIDTH));

  pattern_shreg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_shreg (
    .clk     (Clk),
    .rst     (Reset),
    .cap     (cap),
    .cap_pat (Pattern),
    .set     (set),
    .dec     (dec),
    .sel_idx (sel_idx),
    .idx     (idx),
    .sel_bit (sel_bit)
  );

  // Index of the bit to be presented after the coming edge: the first bit of
  // a fresh frame, the next lower bit, or the first bit of a repeat.
  always_comb begin
    cap = (state_q == ST_IDLE) && Start;
    if (state_q == ST_IDLE)
      sel_idx = len_eff - CNT_W'(1);
    else if (state_q == ST_SEND && idx != '0)
      sel_idx = idx - CNT_W'(1);
    else
      sel_idx = len_q - CNT_W'(1);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      out_q   <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      len_q   <= '0;
`ifdef SERIAL_PATTERN_GEN_LOOP_EN
      gcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      len_q   <= len_d;
`ifdef SERIAL_PATTERN_GEN_LOOP_EN
      gcnt_q  <= gcnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = 1'b0;
    vld_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    len_d   = len_q;
    set     = 1'b0;
    dec     = 1'b0;
`ifdef SERIAL_PATTERN_GEN_LOOP_EN
    gcnt_d  = gcnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          len_d   = len_eff;
          set     = 1'b1;
          out_d   = sel_bit;
          vld_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (Abort) begin
          state_d = ST_IDLE;
        end else if (idx != '0) begin
          dec    = 1'b1;
          out_d  = sel_bit;
          vld_d  = 1'b1;
          busy_d = 1'b1;
        end else begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
`ifdef SERIAL_PATTERN_GEN_LOOP_EN
          if (Loop) begin
            busy_d = 1'b1;
            if (GAP == 0) begin
              set     = 1'b1;
              out_d   = sel_bit;
              vld_d   = 1'b1;
              state_d = ST_SEND;
            end else begin
              gcnt_d  = GAP_LD;
              state_d = ST_GAP;
            end
          end
`endif
        end
      end
`ifdef SERIAL_PATTERN_GEN_LOOP_EN
      ST_GAP: begin
        if (Abort) begin
          state_d = ST_IDLE;
        end else if (gcnt_q == '0) begin
          set     = 1'b1;
          out_d   = sel_bit;
          vld_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_SEND;
        end else begin
          gcnt_d = gcnt_q - GW'(1);
          busy_d = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  assign Out   = out_q;
  assign Valid = vld_q;
  assign Busy  = busy_q;
  assign Done  = done_q;

endmodule

// File: doc/serial_pattern_gen.md
# serial_pattern_gen

Serial bit-pattern transmitter that drives a single-bit line (`Out`) one bit per clock from a parallel pattern. It is the source side of the serial sequence-detector interface: its `Out` connects directly to a detector's `In` on the same `Clk`/`Reset`. It replaces hand-written per-cycle stimulus with a loadable, repeatable frame generator usable in benches and on board.

## Interface
- `WIDTH`, default 12: maximum pattern length in bits.
- `CNT_W`, default 4: bit-counter width; must satisfy 2^CNT_W > WIDTH.
- `GAP`, default 2: idle cycles between repeated frames (loop mode only); 0 means back-to-back frames.

- `Clk` in 1: the single clock; all state changes on the rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `Start` in 1: frame request, sampled only in IDLE.
- `Pattern` in WIDTH: bits to send, captured on an accepted `Start`.
- `Len` in CNT_W: number of bits to send; 0 or any value > WIDTH means WIDTH.
- `Abort` in 1: terminate the current frame.
- `Out` out 1: serial data.
- `Valid` out 1: `Out` carries a frame bit this cycle.
- `Busy` out 1: frame in progress; `Start` ignored.
- `Done` out 1: single-cycle pulse after the last bit of each frame.

## Operation
- States: IDLE, SEND, GAP (GAP exists only with the loop feature).
- IDLE to SEND: `Start`=1 at an edge. Capture `Pattern`, capture effective length L, load bit index L-1. Set `Busy`=1, `Valid`=1, `Out`=`Pattern[L-1]`.
- SEND: each edge decrements the index. `Out` = captured bit at the index, sent MSB-first down to bit 0.
- SEND to IDLE, after bit 0 has been presented: `Done`=1 for one cycle, `Valid`=0, `Out`=0, `Busy`=0.
- `Start` while `Busy`=1 is ignored. It is not queued.
- `Abort`=1 in SEND or GAP: at the next edge go to IDLE with `Out`=0, `Valid`=0, `Busy`=0, and no `Done`. `Abort` has priority over frame completion in the same cycle. `Abort` in IDLE has no effect.
- `Start` and `Abort` both high in IDLE: `Start` is accepted.
- `Reset` asserted, including mid-frame: immediately `Out`=0, `Valid`=0, `Busy`=0, `Done`=0, state IDLE, index 0, captured pattern 0.
- `Pattern` and `Len` changes after capture do not affect the frame in flight.

## Timing
- All outputs are registered (Moore). There is no combinational path from inputs to outputs.
- `Start` accepted at edge k: bit i of the frame is on `Out` from edge k+i to edge k+i+1, for i = 0..L-1.
- `Done` is high from edge k+L to edge k+L+1.
- Earliest next `Start` acceptance is edge k+L+1, i.e. a `Start` held high during the `Done` cycle is accepted at the following edge.
- Frame occupancy: L cycles with `Busy`=1, plus 1 `Done` cycle.

## Configuration
- Macro `SERIAL_PATTERN_GEN_LOOP_EN`.
- Defined:
  - Adds input `Loop` (1 bit), sampled at the last-bit edge.
  - If `Loop`=1, the generator pulses `Done`, stays `Busy`=1, and holds GAP for `GAP` cycles with `Out`=0, `Valid`=0. It then resends the captured pattern with the same timing as a fresh `Start`.
  - With `GAP`=0, the first bit of the next frame follows bit 0 directly, and `Done` coincides with that first bit.
  - `Loop`=0 ends the sequence as in single-shot mode.
- Not defined: no `Loop` port, no GAP state; single-shot only.

## Structure
- Package `serial_pattern_gen_pkg` holds:
  - the state typedef (IDLE/SEND/GAP);
  - the reset constants (pattern 0, index 0);
  - the function returning effective length from `Len`, `WIDTH`.
- One sub-module, `pattern_shreg`: a loadable WIDTH-bit register with index-select output and a down-counting index. The FSM lives in the top module.

## Test plan
- Reset while `Start`=1, then release; `Pattern`=12'b010111001010, `Len`=0, one-cycle `Start` → `Out` = 0,1,0,1,1,1,0,0,1,0,1,0 on consecutive cycles with `Valid`=1, then a single `Done` pulse, `Busy`=0.
- `Pattern`=12'h005, `Len`=3 → `Out`=1,0,1 over 3 cycles; `Done` on the 4th cycle. `Len`=13 → behaves as 12.
- `Start` pulsed at bit 4 of a 12-bit frame, with `Pattern` changed → ignored, frame unchanged. `Start` held through `Done` → new frame's first bit appears exactly one cycle after `Done`.
- `Abort` at bit 5 → next cycle `Out`=0, `Valid`=0, `Busy`=0, and `Done` never asserts. `Reset` pulsed mid-frame (asynchronous, between edges) → outputs 0 immediately.
- With `SERIAL_PATTERN_GEN_LOOP_EN`, `Len`=4, pattern 4'b1011, `GAP`=2, `Loop`=1 → 1,0,1,1,0(gap),0(gap),1,0,1,1…; `Done` once per frame. Drop `Loop` → stops after the current frame. Repeat with `GAP`=0 → no idle cycles between frames.
